// File: rtl/cpu_run_ctrl.sv
// Run/step/burst/halt controller gating the CPU pipeline clock enable,
// with PC breakpoints and an executed-cycle counter.
module cpu_run_ctrl #(
    parameter int CNT_W  = 20,
    parameter int PC_W   = 32,
    parameter int NUM_BP = 2,
    parameter int BL_W   = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [1:0]             mode,
    input  logic                   go,
    input  logic [BL_W-1:0]        burst_len,
    input  logic [NUM_BP-1:0]      bp_en,
    input  logic [NUM_BP*PC_W-1:0] bp_addr,
    input  logic [PC_W-1:0]        pc_i,
    input  logic                   count_clr,
    output logic                   cpu_ce,
    output logic                   halted,
    output logic [NUM_BP-1:0]      bp_hit,
    output logic [CNT_W-1:0]       cycle_count,
    output logic [BL_W-1:0]        remaining
);

    typedef enum logic [1:0] {
        S_HALTED,
        S_RUN,
        S_STEP,
        S_BURST
    } state_t;

    localparam logic [1:0] M_RUN   = 2'b00;
    localparam logic [1:0] M_STEP  = 2'b01;
    localparam logic [1:0] M_BURST = 2'b10;
    localparam logic [1:0] M_HALT  = 2'b11;

    state_t            state_q, state_d;
    logic              skip_q, skip_d;
    logic [NUM_BP-1:0] bp_hit_q, bp_hit_d;
    logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;
    logic [BL_W-1:0]   remaining_q, remaining_d;

    logic [NUM_BP-1:0] match;
    logic              eff_match;
    logic              active;

    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_BP; i++) begin
            match[i] = bp_en[i] && (pc_i == bp_addr[i*PC_W +: PC_W]);
        end
    end

    // The skip flag masks breakpoints for the first cycle after resume,
    // so a run can restart from the PC it stopped on.
    assign eff_match = (state_q == S_RUN || state_q == S_BURST)
                       && !skip_q && (|match);
    assign active    = (state_q != S_HALTED);
    assign cpu_ce    = active && (mode != M_HALT) && !eff_match;

    always_comb begin
        state_d     = state_q;
        skip_d      = 1'b0;
        bp_hit_d    = bp_hit_q;
        remaining_d = remaining_q;
        unique case (state_q)
            S_HALTED: begin
                if (go) begin
                    if (mode == M_RUN) begin
                        state_d = S_RUN;
                    end else if (mode == M_STEP) begin
                        state_d = S_STEP;
                    end else if (mode == M_BURST && burst_len != '0) begin
                        state_d     = S_BURST;
                        remaining_d = burst_len;
                    end
                end
                if (state_d != S_HALTED) begin
                    skip_d   = 1'b1;
                    bp_hit_d = '0;
                end
            end
            S_RUN: begin
                if (eff_match) begin
                    state_d  = S_HALTED;
                    bp_hit_d = bp_hit_q | match;
                end else if (mode == M_HALT) begin
                    state_d = S_HALTED;
                end
            end
            S_STEP: begin
                state_d = S_HALTED;
            end
            S_BURST: begin
                if (eff_match) begin
                    state_d  = S_HALTED;
                    bp_hit_d = bp_hit_q | match;
                end else if (mode == M_HALT) begin
                    state_d = S_HALTED;
                end else begin
                    remaining_d = remaining_q - BL_W'(1);
                    if (remaining_q == BL_W'(1)) begin
                        state_d = S_HALTED;
                    end
                end
            end
        endcase
    end

    always_comb begin
        cycle_count_d = cycle_count_q;
        if (count_clr) begin
            cycle_count_d = '0;
        end else if (cpu_ce) begin
            cycle_count_d = cycle_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_HALTED;
            skip_q        <= 1'b0;
            bp_hit_q      <= '0;
            cycle_count_q <= '0;
            remaining_q   <= '0;
        end else begin
            state_q       <= state_d;
            skip_q        <= skip_d;
            bp_hit_q      <= bp_hit_d;
            cycle_count_q <= cycle_count_d;
            remaining_q   <= remaining_d;
        end
    end

    assign halted      = (state_q == S_HALTED);
    assign bp_hit      = bp_hit_q;
    assign cycle_count = cycle_count_q;
    assign remaining   = remaining_q;

endmodule
